// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle for sync_fifo_flex: producer/consumer side is the
// master, the FIFO itself is the slave.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_errors;

    modport master (
        output write_enable, write_data, read_enable, clear_errors,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable, clear_errors,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost flags, occupancy count and sticky overflow/underflow.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    sync_fifo_flex_if.slave   bus
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be a power of two and >= 2");
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_aw
        $error("sync_fifo_flex: ADDR_WIDTH is derived from DEPTH and must not be overridden");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH out of range 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("sync_fifo_flex: FWFT must be 0 or 1");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        wr_acc     = bus.write_enable && !full_q;
        rd_acc     = bus.read_enable && !empty_q;
        count_next = count_q + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.write_data;
        end
    end

    // Flags are registered from count_next so they move on the same edge as count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count_q     <= count_next;
            full_q      <= (count_next == DEPTH_C);
            empty_q     <= (count_next == '0);
            afull_q     <= (count_next >= AF_C);
            aempty_q    <= (count_next <= AE_C);
            overflow_q  <= (bus.write_enable && full_q) || (overflow_q && !bus.clear_errors);
            underflow_q <= (bus.read_enable && empty_q) || (underflow_q && !bus.clear_errors);
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally; forced to zero while empty.
        assign bus.read_data  = empty_q ? '0 : mem[rd_ptr];
        assign bus.read_valid = !empty_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem[rd_ptr];
                end
            end
        end

        assign bus.read_data  = rdata_q;
        assign bus.read_valid = rvalid_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-read instance and an FWFT
// instance sharing clock and reset, checked with immediate assertions.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(16)) if0 ();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(16)) if1 ();

    sync_fifo_flex #(
        .DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave)
    );

    sync_fifo_flex #(
        .DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_count"}, 32'(if0.count), 0);
        check({tag, "_empty"}, 32'(if0.empty), 1);
        check({tag, "_full"}, 32'(if0.full), 0);
        check({tag, "_aempty"}, 32'(if0.almost_empty), 1);
        check({tag, "_afull"}, 32'(if0.almost_full), 0);
        check({tag, "_rdata"}, 32'(if0.read_data), 0);
        check({tag, "_rvalid"}, 32'(if0.read_valid), 0);
        check({tag, "_ovf"}, 32'(if0.overflow), 0);
        check({tag, "_unf"}, 32'(if0.underflow), 0);
        check({tag, "_f1_rvalid"}, 32'(if1.read_valid), 0);
        check({tag, "_f1_rdata"}, 32'(if1.read_data), 0);
        check({tag, "_f1_empty"}, 32'(if1.empty), 1);
    endtask

    initial begin
        if0.write_enable = 1'b0; if0.write_data = '0; if0.read_enable = 1'b0; if0.clear_errors = 1'b0;
        if1.write_enable = 1'b0; if1.write_data = '0; if1.read_enable = 1'b0; if1.clear_errors = 1'b0;

        // Reset state
        repeat (2) step();
        check_reset0("rst");
        reset_n = 1'b1;
        step();

        // Write 0x01..0x05, then read them back with a one-cycle valid pulse
        for (int i = 0; i < 5; i++) begin
            if0.write_enable = 1'b1;
            if0.write_data   = 8'(i + 1);
            step();
            check("w5_count", 32'(if0.count), 32'(i + 1));
            check("w5_aempty", 32'(if0.almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        if0.write_enable = 1'b0;
        check("w5_empty", 32'(if0.empty), 0);
        check("w5_rvalid_idle", 32'(if0.read_valid), 0);
        for (int i = 0; i < 5; i++) begin
            if0.read_enable = 1'b1;
            step();
            check("r5_rvalid", 32'(if0.read_valid), 1);
            check("r5_rdata", 32'(if0.read_data), 32'(i + 1));
            check("r5_count", 32'(if0.count), 32'(4 - i));
        end
        if0.read_enable = 1'b0;
        step();
        check("r5_rvalid_drop", 32'(if0.read_valid), 0);
        check("r5_rdata_hold", 32'(if0.read_data), 32'h05);
        check("r5_empty", 32'(if0.empty), 1);

        // Fill to full, rejected 17th write, then read+write while full
        for (int i = 0; i < 16; i++) begin
            if0.write_enable = 1'b1;
            if0.write_data   = 8'(8'h10 + i);
            step();
            check("fill_full", 32'(if0.full), (i == 15) ? 1 : 0);
            check("fill_afull", 32'(if0.almost_full), (i >= 13) ? 1 : 0);
        end
        if0.write_data = 8'hAA;
        step();
        check("ovf_count", 32'(if0.count), 16);
        check("ovf_set", 32'(if0.overflow), 1);
        if0.write_enable = 1'b0;
        if0.clear_errors = 1'b1;
        step();
        if0.clear_errors = 1'b0;
        check("ovf_clear", 32'(if0.overflow), 0);
        if0.write_enable = 1'b1;
        if0.read_enable  = 1'b1;
        step();
        check("rw_full_rdata", 32'(if0.read_data), 32'h10);
        check("rw_full_rvalid", 32'(if0.read_valid), 1);
        check("rw_full_count", 32'(if0.count), 15);
        check("rw_full_full", 32'(if0.full), 0);
        check("rw_full_ovf", 32'(if0.overflow), 1);
        if0.write_enable = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            check("drain16_rdata", 32'(if0.read_data), 32'(8'h10 + i));
        end
        if0.read_enable = 1'b0;
        check("drain16_empty", 32'(if0.empty), 1);
        check("drain16_ovf_sticky", 32'(if0.overflow), 1);
        if0.clear_errors = 1'b1;
        step();
        if0.clear_errors = 1'b0;

        // Underflow set, clear, and set winning over clear
        if0.read_enable = 1'b1;
        step();
        check("unf_set", 32'(if0.underflow), 1);
        check("unf_count", 32'(if0.count), 0);
        check("unf_rvalid", 32'(if0.read_valid), 0);
        if0.read_enable  = 1'b0;
        if0.clear_errors = 1'b1;
        step();
        check("unf_clear", 32'(if0.underflow), 0);
        if0.read_enable = 1'b1;
        step();
        check("unf_set_wins", 32'(if0.underflow), 1);
        if0.read_enable = 1'b0;
        step();
        if0.clear_errors = 1'b0;
        check("unf_clear2", 32'(if0.underflow), 0);

        // Read+write on empty: write only, underflow, no valid pulse
        if0.write_enable = 1'b1;
        if0.read_enable  = 1'b1;
        if0.write_data   = 8'h77;
        step();
        if0.write_enable = 1'b0;
        if0.read_enable  = 1'b0;
        check("rw_empty_count", 32'(if0.count), 1);
        check("rw_empty_unf", 32'(if0.underflow), 1);
        check("rw_empty_rvalid", 32'(if0.read_valid), 0);
        if0.read_enable = 1'b1;
        step();
        if0.read_enable = 1'b0;
        check("rw_empty_rdata", 32'(if0.read_data), 32'h77);
        check("rw_empty_rvalid2", 32'(if0.read_valid), 1);

        // Fill to 14 then 20 cycles of simultaneous read+write across wrap
        for (int i = 0; i < 14; i++) begin
            if0.write_enable = 1'b1;
            if0.write_data   = 8'(i);
            step();
        end
        check("s14_count", 32'(if0.count), 14);
        if0.read_enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if0.write_data = 8'(14 + k);
            step();
            check("s14_rdata", 32'(if0.read_data), 32'(k));
            check("s14_count_hold", 32'(if0.count), 14);
            check("s14_afull", 32'(if0.almost_full), 1);
        end
        if0.write_enable = 1'b0;
        for (int k = 20; k < 34; k++) begin
            step();
            check("s14_drain", 32'(if0.read_data), 32'(k));
        end
        if0.read_enable = 1'b0;
        check("s14_empty", 32'(if0.empty), 1);

        // Asynchronous reset in the middle of a stream with 9 words held
        for (int i = 0; i < 9; i++) begin
            if0.write_enable = 1'b1;
            if0.write_data   = 8'(8'hC0 + i);
            step();
        end
        if0.write_enable = 1'b0;
        check("pre_rst_count", 32'(if0.count), 9);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset0("mid_rst");
        step();
        reset_n = 1'b1;
        step();
        if0.write_enable = 1'b1;
        if0.write_data   = 8'h33;
        step();
        if0.write_enable = 1'b0;
        check("post_rst_count", 32'(if0.count), 1);
        if0.read_enable = 1'b1;
        step();
        if0.read_enable = 1'b0;
        check("post_rst_rdata", 32'(if0.read_data), 32'h33);
        check("post_rst_rvalid", 32'(if0.read_valid), 1);

        // FWFT instance: fall-through of first word, then pops
        check("fwft_idle_rvalid", 32'(if1.read_valid), 0);
        if1.write_enable = 1'b1;
        if1.write_data   = 8'h5A;
        step();
        if1.write_enable = 1'b0;
        check("fwft_rvalid", 32'(if1.read_valid), 1);
        check("fwft_rdata", 32'(if1.read_data), 32'h5A);
        step();
        check("fwft_rdata_hold", 32'(if1.read_data), 32'h5A);
        if1.read_enable = 1'b1;
        step();
        if1.read_enable = 1'b0;
        check("fwft_pop_empty", 32'(if1.empty), 1);
        check("fwft_pop_rvalid", 32'(if1.read_valid), 0);
        if1.write_enable = 1'b1;
        if1.write_data   = 8'hA1;
        step();
        if1.write_data   = 8'hA2;
        step();
        if1.write_enable = 1'b0;
        check("fwft_two_head", 32'(if1.read_data), 32'hA1);
        if1.read_enable = 1'b1;
        step();
        check("fwft_two_next", 32'(if1.read_data), 32'hA2);
        check("fwft_two_rvalid", 32'(if1.read_valid), 1);
        step();
        if1.read_enable = 1'b0;
        check("fwft_two_empty", 32'(if1.empty), 1);
        check("fwft_two_unf", 32'(if1.underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit FIFO, generalised in width and depth.
- Adds selectable read mode (standard or first-word-fall-through), programmable almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow error flags.
- Used as the buffering stage between same-clock producer/consumer blocks in the datapath.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; power of two, >= 2.
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_enable  in  1  write request.
- write_data  in  DATA_WIDTH  word to write.
- read_enable  in  1  read request (standard mode) or pop/acknowledge of head word (FWFT).
- read_data  out  DATA_WIDTH  read word.
- read_valid  out  1  read_data holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write rejected since last clear.
- underflow  out  1  sticky: read rejected since last clear.
- clear_errors  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync-safe deassert): count=0, write and read pointers=0, empty=1, full=0, almost_empty=1, almost_full=0, read_data=0, read_valid=0, overflow=0, underflow=0. Storage array is not reset.
- Reset mid-operation discards all content immediately. The first write after release lands at address 0.
- Write is accepted when write_enable && !full. Data is stored at the write pointer, which then increments modulo DEPTH.
- Read is accepted when read_enable && !empty. The read pointer increments modulo DEPTH.
- Flag and count decisions use registered state from the current cycle, before the edge.
- Simultaneous read and write:
  - Both accepted when 0 < count < DEPTH; count is unchanged.
  - When full: read accepted, write rejected (no pass-through); count goes to DEPTH-1 and overflow is set.
  - When empty: write accepted, read rejected; count goes to 1 and underflow is set. In FWFT=0 no read_valid pulse is produced.
- Count update: count_next = count + write_accepted - read_accepted. All flags are registered from count_next, so a flag changes on the same edge as count.
- Standard mode (FWFT=0):
  - Accepted read at edge N: read_data is updated at edge N with the head word and read_valid=1 for exactly one cycle.
  - Latency is 1 cycle from the read_enable sample.
  - read_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - read_data = storage[read pointer] combinationally; read_valid = !empty.
  - A word written at edge N is visible on read_data with read_valid=1 after edge N.
  - Accepted read_enable advances to the next word at the following edge.
  - When empty, read_data is don't-care.
- Sticky errors:
  - overflow sets on write_enable && full; underflow sets on read_enable && empty.
  - clear_errors clears both at the next edge.
  - If a set and a clear occur in the same cycle, set wins.
- Pointer wrap-around is transparent; ordering is strict FIFO across wrap.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) cause an elaboration-time error.

Test Plan:
- Reset, write 0x01..0x05 with no reads, then 5 reads (FWFT=0) -> count 0→5→0; read_data 0x01..0x05, each with a one-cycle read_valid one cycle after read_enable; empty=1 at the end.
- Write 16 words 0x10..0x1F, then a 17th write of 0xAA -> full=1 after the 16th; 17th rejected; overflow=1; reading 16 returns 0x10..0x1F, never 0xAA.
- Read from empty after reset -> underflow=1 and count stays 0; pulse clear_errors -> underflow=0 next cycle; clear concurrent with a new underflow -> underflow stays 1.
- Fill to 14, then 20 cycles of simultaneous read+write with incrementing data -> count stays 14, almost_full=1, output order matches input across pointer wrap.
- FWFT=1: write 0x5A to empty -> read_valid=1 and read_data=0x5A the cycle after the write, before any read_enable; pop -> empty=1, read_valid=0 next cycle.
- Assert reset_n=0 mid-stream with count=9 -> all outputs immediately at reset values; after release, a write of 0x33 then a read returns 0x33.
